// File: rtl/wb_servo_capture.sv
// Wishbone slave measuring RC/servo PWM period and pulse width on two input pins.
// Define SERVO_CAP_IRQ_EN to add the irq output and the IRQEN register at word 5.
module wb_servo_capture #(
   parameter int unsigned PW = 23,
   parameter int unsigned DW = 18
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic        wb_ack_o,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic        servo_in0,
`ifdef SERVO_CAP_IRQ_EN
   output logic        irq,
`endif
   input  logic        servo_in1
);

   localparam int unsigned CW = (PW > DW) ? PW : DW;
   localparam logic [PW-1:0] CNT_MAX = {PW{1'b1}};
   localparam logic [DW-1:0] WL_MAX  = {DW{1'b1}};

   typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_e;

   state_e        state_q [2];
   state_e        state_d [2];
   logic [PW-1:0] cnt_q [2];
   logic [PW-1:0] cnt_d [2];
   logic [PW-1:0] period_q [2];
   logic [PW-1:0] period_d [2];
   logic [DW-1:0] wl_q [2];
   logic [DW-1:0] wl_d [2];
   logic [DW-1:0] width_q [2];
   logic [DW-1:0] width_d [2];
   logic [1:0]    new_q, new_d, ovr_q, ovr_d, tmo_q, tmo_d;
   logic [1:0]    sync1_q, sync2_q, sync3_q, rise_c, fall_c;
   logic          ack_q, acc_c, wr_c;
   logic [31:0]   dat_q, rd_data_c;
   logic [2:0]    reg_sel_c;
   logic [5:0]    w1c_c;
   logic          unused_c;

   assign unused_c  = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:6]};
   assign rise_c    = sync2_q & ~sync3_q;
   assign fall_c    = ~sync2_q & sync3_q;
   assign acc_c     = wb_stb_i & wb_cyc_i & ~ack_q;
   assign wr_c      = acc_c & wb_we_i;
   assign reg_sel_c = wb_adr_i[4:2];
   assign w1c_c     = (wr_c && reg_sel_c == 3'd4) ? wb_dat_i[5:0] : 6'd0;
   assign wb_ack_o  = wb_stb_i & wb_cyc_i & ack_q;
   assign wb_dat_o  = dat_q;

`ifdef SERVO_CAP_IRQ_EN
   logic [3:0] irqen_q;
   logic       irq_q;
   assign irq = irq_q;

   // Level interrupt from the current flags, masked by IRQEN {TMO1,TMO0,NEW1,NEW0}
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         irqen_q <= 4'd0;
         irq_q   <= 1'b0;
      end else begin
         if (wr_c && reg_sel_c == 3'd5) irqen_q <= wb_dat_i[3:0];
         irq_q <= |({tmo_q, new_q} & irqen_q);
      end
   end
`endif

   // Per-channel measurement FSM; hardware flag sets take priority over W1C
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wl_d     = wl_q;
      period_d = period_q;
      width_d  = width_q;
      new_d    = new_q & ~w1c_c[1:0];
      ovr_d    = ovr_q & ~w1c_c[3:2];
      tmo_d    = tmo_q & ~w1c_c[5:4];
      for (int ch = 0; ch < 2; ch++) begin
         case (state_q[ch])
            ST_IDLE: begin
               if (rise_c[ch]) begin
                  cnt_d[ch]   = PW'(1);
                  state_d[ch] = ST_HIGH;
               end
            end
            ST_HIGH, ST_LOW: begin
               if (cnt_q[ch] == CNT_MAX) begin
                  tmo_d[ch]   = 1'b1;
                  cnt_d[ch]   = '0;
                  state_d[ch] = ST_IDLE;
               end else begin
                  cnt_d[ch] = cnt_q[ch] + PW'(1);
                  if (state_q[ch] == ST_HIGH) begin
                     if (fall_c[ch]) begin
                        wl_d[ch]    = (CW'(cnt_q[ch]) > CW'(WL_MAX)) ? WL_MAX : DW'(cnt_q[ch]);
                        state_d[ch] = ST_LOW;
                     end
                  end else if (rise_c[ch]) begin
                     period_d[ch] = cnt_q[ch];
                     width_d[ch]  = wl_q[ch];
                     ovr_d[ch]    = ovr_d[ch] | new_q[ch];
                     new_d[ch]    = 1'b1;
                     cnt_d[ch]    = PW'(1);
                     state_d[ch]  = ST_HIGH;
                  end
               end
            end
            default: state_d[ch] = ST_IDLE;
         endcase
      end
   end

   // Register read mux
   always_comb begin
      rd_data_c = 32'd0;
      case (reg_sel_c)
         3'd0: rd_data_c = 32'(period_q[0]);
         3'd1: rd_data_c = 32'(width_q[0]);
         3'd2: rd_data_c = 32'(period_q[1]);
         3'd3: rd_data_c = 32'(width_q[1]);
         3'd4: rd_data_c = 32'({sync2_q, tmo_q, ovr_q, new_q});
`ifdef SERVO_CAP_IRQ_EN
         3'd5: rd_data_c = 32'(irqen_q);
`endif
         default: rd_data_c = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_q <= 2'd0;
         sync2_q <= 2'd0;
         sync3_q <= 2'd0;
         new_q   <= 2'd0;
         ovr_q   <= 2'd0;
         tmo_q   <= 2'd0;
         ack_q   <= 1'b0;
         dat_q   <= 32'd0;
         for (int ch = 0; ch < 2; ch++) begin
            state_q[ch]  <= ST_IDLE;
            cnt_q[ch]    <= '0;
            wl_q[ch]     <= '0;
            period_q[ch] <= '0;
            width_q[ch]  <= '0;
         end
      end else begin
         sync1_q  <= {servo_in1, servo_in0};
         sync2_q  <= sync1_q;
         sync3_q  <= sync2_q;
         new_q    <= new_d;
         ovr_q    <= ovr_d;
         tmo_q    <= tmo_d;
         ack_q    <= acc_c;
         if (acc_c) dat_q <= rd_data_c;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wl_q     <= wl_d;
         period_q <= period_d;
         width_q  <= width_d;
      end
   end

endmodule

// File: tb/tb_wb_servo_capture.sv
// Directed bench for wb_servo_capture: a default-size instance plus a PW=14/DW=8 instance
// for timeout and width saturation. Pin waveforms are functions of the tick count tk.
module tb_wb_servo_capture;

   logic        clk, resetn;
   logic        cyc, stb_m, stb_t, we;
   logic [31:0] adr, wdat;
   logic        ack_m, ack_t;
   logic [31:0] dat_m, dat_t;
   logic        servo_m0, servo_m1, servo_t0, servo_t1;
`ifdef SERVO_CAP_IRQ_EN
   logic        irq_m, irq_t;
`endif
   int          checks, errors, tk;
   logic [31:0] rdata;

   wb_servo_capture dut (
      .clk(clk), .resetn(resetn), .wb_stb_i(stb_m), .wb_cyc_i(cyc), .wb_ack_o(ack_m),
      .wb_we_i(we), .wb_adr_i(adr), .wb_sel_i(4'hF), .wb_dat_i(wdat), .wb_dat_o(dat_m),
      .servo_in0(servo_m0),
`ifdef SERVO_CAP_IRQ_EN
      .irq(irq_m),
`endif
      .servo_in1(servo_m1)
   );

   wb_servo_capture #(.PW(14), .DW(8)) dut_t (
      .clk(clk), .resetn(resetn), .wb_stb_i(stb_t), .wb_cyc_i(cyc), .wb_ack_o(ack_t),
      .wb_we_i(we), .wb_adr_i(adr), .wb_sel_i(4'hF), .wb_dat_i(wdat), .wb_dat_o(dat_t),
      .servo_in0(servo_t0),
`ifdef SERVO_CAP_IRQ_EN
      .irq(irq_t),
`endif
      .servo_in1(servo_t1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ch0: 20000 period, 1500 high (1000 high from tick 40000); ch1: 18000 period, 2000 high
   function automatic logic pin_m0(input int t);
      int h;
      if (t < 0) return 1'b0;
      h = (t >= 40000) ? 1000 : 1500;
      return (t % 20000) < h;
   endfunction

   function automatic logic pin_m1(input int t);
      if (t < 0) return 1'b0;
      return (t % 18000) < 2000;
   endfunction

   // Timeout instance: pulses at 0 and 500 (100 high), silence, then 300/1000 from 20000
   function automatic logic pin_t0(input int t);
      if (t < 0) return 1'b0;
      if (t < 100 || (t >= 500 && t < 600)) return 1'b1;
      if (t >= 20000) return ((t - 20000) % 1000) < 300;
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      servo_m0 = pin_m0(tk);
      servo_m1 = pin_m1(tk);
      servo_t0 = pin_t0(tk);
      @(negedge clk);
      tk++;
   endtask

   task automatic wait_tick(input int t);
      chk("schedule", 32'(tk <= t), 32'd1);
      while (tk < t) tick();
   endtask

   // Two-cycle bus access: ack must be high after the first edge and low after the second
   task automatic bus(input logic tsel, input logic wr, input logic [2:0] r,
                      input logic [31:0] wd, output logic [31:0] rd);
      adr  = {27'd0, r, 2'b00};
      we   = wr;
      wdat = wd;
      cyc  = 1'b1;
      if (tsel) stb_t = 1'b1; else stb_m = 1'b1;
      tick();
      chk("ack_high", 32'(tsel ? ack_t : ack_m), 32'd1);
      rd = tsel ? dat_t : dat_m;
      tick();
      chk("ack_one_cycle", 32'(tsel ? ack_t : ack_m), 32'd0);
      cyc = 1'b0; stb_m = 1'b0; stb_t = 1'b0; we = 1'b0;
   endtask

   task automatic rd_chk(input logic tsel, input logic [2:0] r, input logic [31:0] exp,
                         input string tag);
      logic [31:0] d;
      bus(tsel, 1'b0, r, 32'd0, d);
      chk(tag, d, exp);
   endtask

   task automatic wr(input logic tsel, input logic [2:0] r, input logic [31:0] wd);
      logic [31:0] d;
      bus(tsel, 1'b1, r, wd, d);
   endtask

   initial begin
      checks = 0; errors = 0; tk = -100;
      resetn = 1'b0; cyc = 1'b0; stb_m = 1'b0; stb_t = 1'b0; we = 1'b0;
      adr = 32'd0; wdat = 32'd0;
      servo_m0 = 1'b0; servo_m1 = 1'b0; servo_t0 = 1'b0; servo_t1 = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ack", 32'(ack_m), 32'd0);
      chk("reset_dat", dat_m, 32'd0);
      chk("reset_dat_t", dat_t, 32'd0);
`ifdef SERVO_CAP_IRQ_EN
      chk("reset_irq", 32'(irq_m), 32'd0);
`endif
      resetn = 1'b1;

      // Every register reads 0 after reset
      for (int r = 0; r < 8; r++) begin
         bus(1'b0, 1'b0, 3'(r), 32'd0, rdata);
         chk("reset_reg", rdata, 32'd0);
      end
`ifdef SERVO_CAP_IRQ_EN
      wait_tick(100);
      wr(1'b1, 3'd5, 32'h2);
`endif

      // Timeout: last rise at 500, TMO0 appears on the edge after tick 16885
      wait_tick(16885);
      rd_chk(1'b1, 3'd4, 32'h01, "t_status_pre_tmo");
      rd_chk(1'b1, 3'd4, 32'h11, "t_status_tmo");
      rd_chk(1'b1, 3'd0, 32'd500, "t_period_kept");
      rd_chk(1'b1, 3'd1, 32'd100, "t_width_kept");
`ifdef SERVO_CAP_IRQ_EN
      chk("t_irq_tmo_masked", 32'(irq_t), 32'd0);
      wr(1'b1, 3'd5, 32'h4);
      chk("t_irq_tmo_enabled", 32'(irq_t), 32'd1);
`endif

      // ch1 second rise at 18000: not visible 2 edges later, visible 3 edges later
      wait_tick(18002);
      rd_chk(1'b0, 3'd4, 32'h80, "status_ch1_pre");
      rd_chk(1'b0, 3'd4, 32'h82, "status_ch1_new");
      rd_chk(1'b0, 3'd2, 32'd18000, "period1");
      rd_chk(1'b0, 3'd3, 32'd2000, "width1");

      wait_tick(20003);
      rd_chk(1'b0, 3'd4, 32'h43, "status_ch0_new");
      rd_chk(1'b0, 3'd0, 32'd20000, "period0_first");
      rd_chk(1'b0, 3'd1, 32'd1500, "width0_first");

      // Timeout instance re-armed at 20000, captures at 21000 with width saturated to 255
      wait_tick(21003);
      rd_chk(1'b1, 3'd4, 32'h55, "t_status_rearm");
      rd_chk(1'b1, 3'd0, 32'd1000, "t_period_rearm");
      rd_chk(1'b1, 3'd1, 32'd255, "t_width_sat");

      // Third ch0 rise at 40000 sets OVR0
      wait_tick(40002);
      rd_chk(1'b0, 3'd4, 32'h4B, "status_pre_ovr");
      rd_chk(1'b0, 3'd4, 32'h4F, "status_ovr0");
      rd_chk(1'b0, 3'd0, 32'd20000, "period0_second");
      rd_chk(1'b0, 3'd1, 32'd1500, "width0_second");
      wr(1'b0, 3'd4, 32'h05);
      rd_chk(1'b0, 3'd4, 32'h4A, "status_w1c");

      // W1C NEW1 on the same edge ch1 captures: set wins
      wait_tick(54002);
      wr(1'b0, 3'd4, 32'h02);
      rd_chk(1'b0, 3'd4, 32'h8A, "status_set_wins");
      rd_chk(1'b0, 3'd2, 32'd18000, "period1_again");
      rd_chk(1'b0, 3'd3, 32'd2000, "width1_again");

      wait_tick(59000);
      wr(1'b0, 3'd5, 32'h1);
`ifdef SERVO_CAP_IRQ_EN
      rd_chk(1'b0, 3'd5, 32'h1, "irqen_rd");
      chk("irq_masked_new1", 32'(irq_m), 32'd0);
`else
      rd_chk(1'b0, 3'd5, 32'h0, "adr5_rd");
`endif

      // ch0 capture at 60000 after flags were cleared: NEW0 without OVR0
      wait_tick(60003);
      rd_chk(1'b0, 3'd4, 32'h4B, "status_after_clear");
      rd_chk(1'b0, 3'd0, 32'd20000, "period0_third");
      rd_chk(1'b0, 3'd1, 32'd1000, "width0_third");
      rd_chk(1'b0, 3'd2, 32'd18000, "period1_indep");
      rd_chk(1'b0, 3'd3, 32'd2000, "width1_indep");
`ifdef SERVO_CAP_IRQ_EN
      chk("irq_new0", 32'(irq_m), 32'd1);
      wr(1'b0, 3'd4, 32'h01);
      chk("irq_cleared", 32'(irq_m), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
